// File: rtl/joystick_conditioner.sv
// Conditions one player's raw up/down pins into debounced, conflict-resolved
// active-low paddle controls plus one-cycle press pulses.
module joystick_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  output logic       control_up,
  output logic       control_down,
  output logic       press_up_pulse,
  output logic       press_down_pulse,
  output logic [1:0] dir_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    UP       = 2'b01,
    DOWN     = 2'b10,
    CONFLICT = 2'b11
  } dir_t;

  localparam logic             RELEASED_RAW = (RAW_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // Channel index 0 is up, 1 is down.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       pressed;
  logic [1:0]       stable;
  logic [1:0]       stable_q;
  logic [CNT_W-1:0] cnt [2];
  dir_t             state;
  dir_t             next_state;

  assign raw     = {btn_down_raw, btn_up_raw};
  assign pressed = s2 ^ {2{RELEASED_RAW}};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which is what makes s1 -> s2 a real two-stage chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= {2{RELEASED_RAW}};
      s2 <= {2{RELEASED_RAW}};
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // NOTE: the counters are plain registers, not a RAM, so they are reset
  // explicitly; an in-flight debounce must not survive a reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        stable[i] <= 1'b0;
        cnt[i]    <= '0;
      end else if (pressed[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable[i] <= pressed[i];
        cnt[i]    <= '0;
      end else begin
        cnt[i] <= cnt[i] + CNT_ONE;
      end
    end
  end

  // CONFLICT is only left once both buttons are released, never sideways.
  function automatic dir_t next_dir(dir_t cur, logic up, logic down);
    case (cur)
      IDLE:     next_dir = (up && down) ? CONFLICT : up ? UP : down ? DOWN : IDLE;
      UP:       next_dir = down ? CONFLICT : (!up ? IDLE : UP);
      DOWN:     next_dir = up ? CONFLICT : (!down ? IDLE : DOWN);
      CONFLICT: next_dir = (!up && !down) ? IDLE : CONFLICT;
      default:  next_dir = IDLE;
    endcase
  endfunction

  assign next_state = next_dir(state, stable[0], stable[1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      control_up       <= 1'b1;
      control_down     <= 1'b1;
      press_up_pulse   <= 1'b0;
      press_down_pulse <= 1'b0;
      stable_q         <= 2'b00;
    end else begin
      state            <= next_state;
      control_up       <= (next_state != UP);
      control_down     <= (next_state != DOWN);
      press_up_pulse   <= stable[0] & ~stable_q[0];
      press_down_pulse <= stable[1] & ~stable_q[1];
      stable_q         <= stable;
    end
  end

  assign dir_state = state;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
module tb_joystick_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up_raw = 1'b1;
  logic       btn_down_raw = 1'b1;
  logic       control_up;
  logic       control_down;
  logic       press_up_pulse;
  logic       press_down_pulse;
  logic [1:0] dir_state;

  int checks = 0;
  int errors = 0;

  joystick_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8),
    .RAW_ACTIVE_LOW(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_up_raw(btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .control_up(control_up),
    .control_down(control_down),
    .press_up_pulse(press_up_pulse),
    .press_down_pulse(press_down_pulse),
    .dir_state(dir_state)
  );

  always #5 clock = ~clock;

  // Observed vector: {control_up, control_down, dir_state, press_up, press_down}
  localparam logic [5:0] V_IDLE      = 6'b11_00_00;
  localparam logic [5:0] V_UP        = 6'b01_01_00;
  localparam logic [5:0] V_UP_PULSE  = 6'b01_01_10;
  localparam logic [5:0] V_DOWN      = 6'b10_10_00;
  localparam logic [5:0] V_DOWN_PUL  = 6'b10_10_01;
  localparam logic [5:0] V_CONF      = 6'b11_11_00;
  localparam logic [5:0] V_CONF_DN   = 6'b11_11_01;
  localparam logic [5:0] V_CONF_BOTH = 6'b11_11_11;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {control_up, control_down, dir_state, press_up_pulse, press_down_pulse};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset with both pins released.
    tick(1);
    check("in_reset", V_IDLE);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_after_reset", V_IDLE);
    end

    // Up press: control_up falls on the 7th edge with a one-cycle pulse.
    btn_up_raw = 1'b0;
    tick(6);
    check("up_edge6", V_IDLE);
    tick(1);
    check("up_edge7", V_UP_PULSE);
    tick(1);
    check("up_pulse_end", V_UP);

    // Down glitches of 3 cycles never qualify.
    for (int g = 0; g < 5; g++) begin
      btn_down_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        check("glitch_low", V_UP);
      end
      btn_down_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        check("glitch_high", V_UP);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_settle", V_UP);
    end

    // Down while up held -> CONFLICT, with down pulse.
    btn_down_raw = 1'b0;
    tick(6);
    check("conf_edge6", V_UP);
    tick(1);
    check("conf_edge7", V_CONF_DN);
    tick(1);
    check("conf_pulse_end", V_CONF);

    // Release down only: stays CONFLICT, no release pulse.
    btn_down_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("conf_down_released", V_CONF);
    end

    // Release up: IDLE on the 7th edge.
    btn_up_raw = 1'b1;
    tick(6);
    check("rel_up_edge6", V_CONF);
    tick(1);
    check("rel_up_edge7", V_IDLE);
    tick(4);
    check("idle_again", V_IDLE);

    // Simultaneous press from IDLE goes straight to CONFLICT.
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("both_waiting", V_IDLE);
    end
    tick(1);
    check("both_edge7", V_CONF_BOTH);
    tick(1);
    check("both_pulse_end", V_CONF);
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b1;
    tick(6);
    check("both_rel_edge6", V_CONF);
    tick(1);
    check("both_rel_edge7", V_IDLE);
    tick(3);

    // Hold down, then reset mid-operation.
    btn_down_raw = 1'b0;
    tick(6);
    check("down_edge6", V_IDLE);
    tick(1);
    check("down_edge7", V_DOWN_PUL);
    tick(3);
    check("down_held", V_DOWN);
    reset = 1'b1;
    tick(1);
    check("reset_mid_1", V_IDLE);
    tick(1);
    check("reset_mid_2", V_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("requalify_wait", V_IDLE);
    end
    tick(1);
    check("requalify_edge7", V_DOWN_PUL);
    tick(1);
    check("requalify_pulse_end", V_DOWN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
